// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// the program terminator word used by the debug unit and test benches.
package inst_mem_loader_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_DONE = 2'd2,
        LDR_ERR  = 2'd3
    } ldr_state_t;

    localparam logic [31:0] LDR_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; the fourth byte is
// forwarded straight into the word so it can be registered by the caller.
module inst_mem_loader_byte_packer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_count;
    logic [23:0] r_asm;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= 2'd0;
            r_asm   <= 24'd0;
        end else if (i_clear) begin
            // A byte arriving with the clear becomes byte 0 of the fresh word.
            r_count <= {1'b0, i_valid};
            if (i_valid) begin
                r_asm[7:0] <= i_data;
            end
        end else if (i_valid) begin
            case (r_count)
                2'd0:    r_asm[7:0]   <= i_data;
                2'd1:    r_asm[15:8]  <= i_data;
                2'd2:    r_asm[23:16] <= i_data;
                default: ;
            endcase
            r_count <= r_count + 2'd1;
        end
    end

    assign o_word       = {i_data, r_asm};
    assign o_word_valid = i_valid && !i_clear && (r_count == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Debug loader: packs UART bytes into instruction words, writes them to
// consecutive addresses and holds the core in reset until the terminator.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter int               MEM_DEPTH = 256,
    parameter logic [NBITS-1:0] HALT_WORD = NBITS'(LDR_HALT_WORD),
    localparam int              CW        = $clog2(MEM_DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_data,
    output logic             o_inst_mem_wr_en,
    output logic [NBITS-1:0] o_inst_mem_addr,
    output logic [NBITS-1:0] o_inst_mem_data,
    output logic             o_cpu_rst,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic [CW-1:0]    o_word_count,
    output ldr_state_t       o_state
);

    ldr_state_t       r_state;
    ldr_state_t       w_state_next;
    logic             w_pack_valid;
    logic [31:0]      w_word;
    logic             w_word_valid;
    logic             r_wr_en;
    logic [NBITS-1:0] r_addr;
    logic [NBITS-1:0] r_data;
    logic [CW-1:0]    r_word_count;

    // Bytes only count while loading; outside LOAD they are dropped.
    assign w_pack_valid = i_rx_valid && (r_state == LDR_LOAD);

    inst_mem_loader_byte_packer u_byte_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (w_pack_valid),
        .i_data       (i_rx_data),
        .i_clear      (i_start),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= LDR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LDR_IDLE: begin
                if (i_start) w_state_next = LDR_LOAD;
            end
            LDR_LOAD: begin
                // Exit is decided in the write cycle; terminator beats overflow.
                if (i_start) begin
                    w_state_next = LDR_LOAD;
                end else if (r_wr_en) begin
                    if (r_data == HALT_WORD) begin
                        w_state_next = LDR_DONE;
                    end else if (r_word_count == CW'(MEM_DEPTH)) begin
                        w_state_next = LDR_ERR;
                    end
                end
            end
            LDR_DONE: begin
                if (i_start) w_state_next = LDR_LOAD;
            end
            LDR_ERR: begin
                if (i_start) w_state_next = LDR_LOAD;
            end
            default: w_state_next = LDR_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_en      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_word_count <= '0;
        end else if (i_start) begin
            r_wr_en      <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_wr_en <= w_word_valid;
            if (w_word_valid) begin
                r_data       <= NBITS'(w_word);
                r_addr       <= NBITS'({r_word_count, 2'b00});
                r_word_count <= r_word_count + CW'(1);
            end
        end
    end

    assign o_inst_mem_wr_en = r_wr_en;
    assign o_inst_mem_addr  = r_addr;
    assign o_inst_mem_data  = r_data;
    assign o_word_count     = r_word_count;
    assign o_busy           = (r_state == LDR_LOAD);
    assign o_done           = (r_state == LDR_DONE);
    assign o_overflow       = (r_state == LDR_ERR);
    assign o_cpu_rst        = (r_state != LDR_DONE);
    assign o_state          = r_state;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: table vectors, directed multi-cycle sequences
// and random programs checked against a word-level model of the load.
module tb_inst_mem_loader;
    import inst_mem_loader_pkg::*;

    localparam int NBITS     = 32;
    localparam int MEM_DEPTH = 4;
    localparam int CW        = $clog2(MEM_DEPTH) + 1;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic             i_rx_valid;
    logic [7:0]       i_rx_data;
    logic             o_inst_mem_wr_en;
    logic [NBITS-1:0] o_inst_mem_addr;
    logic [NBITS-1:0] o_inst_mem_data;
    logic             o_cpu_rst;
    logic             o_busy;
    logic             o_done;
    logic             o_overflow;
    logic [CW-1:0]    o_word_count;
    ldr_state_t       o_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_byte_cyc = 0;
    logic [63:0] exp_q[$];
    int          wr_cyc_q[$];
    logic [63:0] mon_e;

    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] exp_word;
        ldr_state_t  exp_state;
    } vec_t;

    vec_t vecs[7];

    inst_mem_loader #(
        .NBITS     (NBITS),
        .MEM_DEPTH (MEM_DEPTH),
        .HALT_WORD (LDR_HALT_WORD)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_start          (i_start),
        .i_rx_valid       (i_rx_valid),
        .i_rx_data        (i_rx_data),
        .o_inst_mem_wr_en (o_inst_mem_wr_en),
        .o_inst_mem_addr  (o_inst_mem_addr),
        .o_inst_mem_data  (o_inst_mem_data),
        .o_cpu_rst        (o_cpu_rst),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_overflow       (o_overflow),
        .o_word_count     (o_word_count),
        .o_state          (o_state)
    );

    // Clock and cycle counter
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the head of the expected queue
    always @(negedge i_clk) begin
        if (o_inst_mem_wr_en === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                         o_inst_mem_addr, o_inst_mem_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {32'd0, o_inst_mem_addr}, {32'd0, mon_e[63:32]});
                chk("wr_data", {32'd0, o_inst_mem_data}, {32'd0, mon_e[31:0]});
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid    = 1'b1;
        i_rx_data     = b;
        last_byte_cyc = cyc;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic expect_write(input int addr, input logic [31:0] data);
        exp_q.push_back({32'(addr), data});
    endtask

    task automatic check_state(input ldr_state_t st, input int wc);
        chk("state", {62'd0, o_state}, {62'd0, st});
        chk("cpu_rst", {63'd0, o_cpu_rst}, {63'd0, (st != LDR_DONE)});
        chk("busy", {63'd0, o_busy}, {63'd0, (st == LDR_LOAD)});
        chk("done", {63'd0, o_done}, {63'd0, (st == LDR_DONE)});
        chk("overflow", {63'd0, o_overflow}, {63'd0, (st == LDR_ERR)});
        chk("word_count", 64'(o_word_count), 64'(wc));
    endtask

    task automatic check_reset_values();
        check_state(LDR_IDLE, 0);
        chk("rst_wr_en", {63'd0, o_inst_mem_wr_en}, 64'd0);
        chk("rst_addr", {32'd0, o_inst_mem_addr}, 64'd0);
        chk("rst_data", {32'd0, o_inst_mem_data}, 64'd0);
    endtask

    task automatic check_drained();
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [7:0]  bq[$];
        logic [31:0] w;
        ldr_state_t  m_state;
        int          m_cnt;
        int          c0;

        vecs[0] = '{8'h20, 8'h08, 8'h01, 8'h00, 32'h0001_0820, LDR_LOAD};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, LDR_DONE};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 32'h7FFF_FFFF, LDR_LOAD};
        vecs[3] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFE, LDR_LOAD};
        vecs[4] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h1234_5678, LDR_LOAD};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000, LDR_LOAD};
        vecs[6] = '{8'h01, 8'h00, 8'h00, 8'h80, 32'h8000_0001, LDR_LOAD};

        i_rst = 1'b1; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
        ticks(2);
        i_rst = 1'b0;
        tick();
        check_reset_values();

        // Bytes in IDLE are ignored
        for (int i = 0; i < 4; i++) send_byte(8'h55);
        tick();
        check_state(LDR_IDLE, 0);

        // Basic load with terminator, including write latency and exit timing
        pulse_start();
        check_state(LDR_LOAD, 0);
        wr_cyc_q.delete();
        expect_write(0, 32'h0001_0820);
        expect_write(4, 32'hFFFF_FFFF);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        check_state(LDR_LOAD, 2);
        tick();
        check_state(LDR_DONE, 2);
        chk("basic_write_count", 64'(wr_cyc_q.size()), 64'd2);
        chk("basic_latency", 64'(wr_cyc_q[wr_cyc_q.size()-1]), 64'(last_byte_cyc + 1));
        check_drained();
        send_byte(8'h12);
        ticks(2);
        check_state(LDR_DONE, 2);

        // Reload from DONE
        pulse_start();
        check_state(LDR_LOAD, 0);
        expect_write(0, 32'h4433_2211);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        tick();
        check_drained();

        // Back-to-back bytes: strobes every 4 cycles
        pulse_start();
        wr_cyc_q.delete();
        expect_write(0, 32'h0302_0100);
        expect_write(4, 32'h0706_0504);
        expect_write(8, 32'hFFFF_FFFF);
        c0 = cyc;
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        ticks(2);
        chk("b2b_write_count", 64'(wr_cyc_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < wr_cyc_q.size(); i++)
            chk("b2b_write_cycle", 64'(wr_cyc_q[i] - c0), 64'(4 * (i + 1)));
        check_state(LDR_DONE, 3);
        check_drained();

        // Table vectors: single word, then state
        for (int i = 0; i < 7; i++) begin
            pulse_start();
            expect_write(0, vecs[i].exp_word);
            send_byte(vecs[i].b0); send_byte(vecs[i].b1);
            send_byte(vecs[i].b2); send_byte(vecs[i].b3);
            tick();
            check_state(vecs[i].exp_state, 1);
            check_drained();
        end

        // Restart after two bytes discards the partial word
        pulse_start();
        send_byte(8'h01); send_byte(8'h02);
        pulse_start();
        expect_write(0, 32'hDDCC_BBAA);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        ticks(2);
        check_state(LDR_LOAD, 1);
        check_drained();

        // Restart coinciding with a byte: that byte becomes byte 0
        pulse_start();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        i_start = 1'b1; i_rx_valid = 1'b1; i_rx_data = 8'hAA;
        tick();
        i_start = 1'b0; i_rx_valid = 1'b0;
        expect_write(0, 32'hDDCC_BBAA);
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        ticks(2);
        check_state(LDR_LOAD, 1);
        check_drained();

        // Overflow: memory fills without a terminator
        pulse_start();
        for (int k = 0; k < 4; k++)
            expect_write(4 * k, {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
        for (int i = 0; i < 16; i++) send_byte(8'(i + 1));
        tick();
        check_state(LDR_ERR, 4);
        send_byte(8'h42);
        ticks(2);
        check_state(LDR_ERR, 4);
        check_drained();
        pulse_start();
        check_state(LDR_LOAD, 0);

        // Asynchronous reset mid-load
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        #2;
        i_rst = 1'b1;
        #1;
        check_reset_values();
        tick();
        i_rst = 1'b0;
        tick();
        send_byte(8'h40);
        ticks(3);
        check_state(LDR_IDLE, 0);
        check_drained();
        pulse_start();
        expect_write(0, 32'h8765_4321);
        send_byte(8'h21); send_byte(8'h43); send_byte(8'h65); send_byte(8'h87);
        tick();
        check_drained();

        // Random programs against a word-level model
        for (int t = 0; t < 20; t++) begin
            bq.delete();
            for (int k = $urandom_range(1, 6); k > 0; k--) begin
                w = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                for (int j = 0; j < 4; j++) bq.push_back(w[8*j +: 8]);
            end
            for (int j = $urandom_range(0, 3); j > 0; j--) bq.push_back(8'($urandom));

            m_state = LDR_LOAD;
            m_cnt   = 0;
            for (int k = 0; k < bq.size() / 4; k++) begin
                if (m_state != LDR_LOAD) break;
                w = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
                expect_write(4 * k, w);
                m_cnt++;
                if (w == LDR_HALT_WORD)       m_state = LDR_DONE;
                else if (m_cnt == MEM_DEPTH)  m_state = LDR_ERR;
            end

            pulse_start();
            for (int j = 0; j < bq.size(); j++) begin
                send_byte(bq[j]);
                ticks($urandom_range(0, 2));
            end
            ticks(3);
            check_state(m_state, m_cnt);
            check_drained();
            exp_q.delete();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
